modexp_ctrl: RTL

// - Upstream sequencer for the 1024-bit Montgomery multiplier: computes result = X^E mod M.
// - Uses left-to-right binary square-and-multiply and issues one multiplication at a time.
// - Drives the multiplier's start/a/b/m inputs and consumes its result/done handshake.
// - Caller supplies R mod M and R^2 mod M (R = 2^WIDTH); this block does no reductions itself.

---
 rtl/modexp_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier: result = X^E mod M.
// Optional `MODEXP_SKIP_LZ_EN` starts the bit scan at the most significant set bit of E.
module modexp_ctrl #(
    parameter int unsigned WIDTH   = 1024,
    parameter int unsigned E_WIDTH = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_r2,
    output logic               mm_start,
    output logic [WIDTH-1:0]   mm_a,
    output logic [WIDTH-1:0]   mm_b,
    output logic [WIDTH-1:0]   mm_m,
    input  logic [WIDTH-1:0]   mm_result,
    input  logic               mm_done,
    output logic               busy,
    output logic [WIDTH-1:0]   result,
    output logic               done
);

    localparam int unsigned IdxW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(E_WIDTH - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StNext  = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;

    localparam logic [1:0] OpToMont   = 2'd0;
    localparam logic [1:0] OpSqr      = 2'd1;
    localparam logic [1:0] OpMul      = 2'd2;
    localparam logic [1:0] OpFromMont = 2'd3;

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [IdxW-1:0]    r_idx;
    logic [WIDTH-1:0]   r_x;
    logic [E_WIDTH-1:0] r_e;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_r2;
    logic [WIDTH-1:0]   r_xm;
    logic [WIDTH-1:0]   r_a;
    logic               r_mm_start;
    logic [WIDTH-1:0]   r_mm_a;
    logic [WIDTH-1:0]   r_mm_b;
    logic [WIDTH-1:0]   r_mm_m;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [IdxW-1:0]    w_first_idx;
    logic [1:0]         w_first_op;
    logic               w_last;

    assign w_last = (r_idx == '0);

`ifdef MODEXP_SKIP_LZ_EN
    logic [IdxW-1:0] w_msb_idx;

    always_comb begin
        w_msb_idx = '0;
        for (int i = 0; i < int'(E_WIDTH); i++) begin
            if (r_e[i]) begin
                w_msb_idx = IdxW'(i);
            end
        end
    end

    // With E = 0 every squaring leaves A = R unchanged, so go straight to the exit conversion.
    assign w_first_idx = w_msb_idx;
    assign w_first_op  = (r_e == '0) ? OpFromMont : OpSqr;
`else
    assign w_first_idx = IdxTop;
    assign w_first_op  = OpSqr;
`endif

    always_comb begin
        w_op_a = r_a;
        w_op_b = r_a;
        case (r_op)
            OpToMont: begin
                w_op_a = r_x;
                w_op_b = r_r2;
            end
            OpMul:      w_op_b = r_xm;
            OpFromMont: w_op_b = WIDTH'(1);
            default:    w_op_b = r_a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_op       <= OpToMont;
            r_idx      <= '0;
            r_x        <= '0;
            r_e        <= '0;
            r_r        <= '0;
            r_r2       <= '0;
            r_xm       <= '0;
            r_a        <= '0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                StIdle: begin
                    // A start coinciding with the done pulse belongs to the finished run.
                    if (start && !r_done) begin
                        r_x     <= in_x;
                        r_e     <= in_e;
                        r_r     <= in_r;
                        r_r2    <= in_r2;
                        r_mm_m  <= in_m;
                        r_busy  <= 1'b1;
                        r_op    <= OpToMont;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    r_mm_a     <= w_op_a;
                    r_mm_b     <= w_op_b;
                    r_mm_start <= 1'b1;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (mm_done) begin
                        if (r_op == OpToMont) begin
                            r_xm <= mm_result;
                        end else begin
                            r_a <= mm_result;
                        end
                        r_state <= StNext;
                    end
                end
                StNext: begin
                    r_state <= StIssue;
                    case (r_op)
                        OpToMont: begin
                            r_a   <= r_r;
                            r_idx <= w_first_idx;
                            r_op  <= w_first_op;
                        end
                        OpSqr: begin
                            if (r_e[r_idx]) begin
                                r_op <= OpMul;
                            end else if (w_last) begin
                                r_op <= OpFromMont;
                            end else begin
                                r_idx <= r_idx - IdxW'(1);
                            end
                        end
                        OpMul: begin
                            if (w_last) begin
                                r_op <= OpFromMont;
                            end else begin
                                r_idx <= r_idx - IdxW'(1);
                                r_op  <= OpSqr;
                            end
                        end
                        default: r_state <= StFin;
                    endcase
                end
                StFin: begin
                    r_result <= r_a;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mm_start = r_mm_start;
    assign mm_a     = r_mm_a;
    assign mm_b     = r_mm_b;
    assign mm_m     = r_mm_m;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule
